// File: rtl/fpu_sub_arbiter_if.sv
// fpu_sub_arbiter_if: requester, response and FPU-side signals of the shared FP add/sub arbiter
// slave  : arbiter side (takes requests and FPU results, drives grants, responses and FPU issue)
// master : environment side (requesters plus the shared FPU datapath)
interface fpu_sub_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   hold;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     req_op;
  logic [NUM_REQ*32-1:0]  req_a;
  logic [NUM_REQ*32-1:0]  req_b;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [31:0]            rsp_data;
  logic [31:0]            fpu_a;
  logic [31:0]            fpu_b;
  logic                   fpu_valid_in;
  logic [31:0]            fpu_ans;
  logic                   fpu_valid_out;
  logic                   busy;
  logic                   tag_err;
  modport slave (
    input  hold, req_valid, req_op, req_a, req_b, fpu_ans, fpu_valid_out,
    output req_ready, rsp_valid, rsp_data, fpu_a, fpu_b, fpu_valid_in, busy, tag_err
  );
  modport master (
    output hold, req_valid, req_op, req_a, req_b, fpu_ans, fpu_valid_out,
    input  req_ready, rsp_valid, rsp_data, fpu_a, fpu_b, fpu_valid_in, busy, tag_err
  );
endinterface

// File: rtl/fpu_sub_arbiter.sv
// fpu_sub_arbiter: round-robin sharing of one pipelined FP subtractor among NUM_REQ requesters
// clk, reset  : clock, asynchronous active-high reset
// io_bus      : requests (valid/ready, op, operands), hold, per-requester result strobes with shared
//               result data, registered FPU issue (a, b, valid_in), FPU result (ans, valid_out),
//               busy and sticky tag_err
module fpu_sub_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PIPE_LAT     = 3,
  parameter int MAX_INFLIGHT = 2
) (
  input logic              clk,
  input logic              reset,
  fpu_sub_arbiter_if.slave io_bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [31:0]        w_a [NUM_REQ];
  logic [31:0]        w_b [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_rsp_next;
  logic [IW-1:0]      w_sel;
  logic               w_hit;
  logic               w_mis;

  logic [CW-1:0]      r_cnt [NUM_REQ];
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_issue_id;
  logic               r_fpu_valid_in;
  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [PIPE_LAT:0]  r_tag_v;
  logic [IW-1:0]      r_tag_id [PIPE_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [31:0]        r_rsp_data;
  logic               r_tag_err;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_a[g]    = io_bus.req_a[32*g +: 32];
    assign w_b[g]    = io_bus.req_b[32*g +: 32];
    assign w_elig[g] = io_bus.req_valid[g] & (r_cnt[g] < CW'(MAX_INFLIGHT)) & ~io_bus.hold;
  end

  // Scan from farthest to nearest after ptr so the last hit is the first eligible in RR order.
  always_comb begin
    w_sel = r_ptr;
    w_hit = 1'b0;
    for (int j = NUM_REQ; j >= 1; j--) begin
      if (w_elig[IW'((int'(r_ptr) + j) % NUM_REQ)]) begin
        w_hit = 1'b1;
        w_sel = IW'((int'(r_ptr) + j) % NUM_REQ);
      end
    end
    w_grant = (w_hit && !reset) ? (NUM_REQ'(1) << w_sel) : '0;
  end

  // The last tag entry lines up with the FPU result; any disagreement suppresses the response.
  assign w_mis      = io_bus.fpu_valid_out != r_tag_v[PIPE_LAT];
  assign w_rsp_next = (io_bus.fpu_valid_out && !w_mis) ? (NUM_REQ'(1) << r_tag_id[PIPE_LAT]) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr          <= IW'(NUM_REQ - 1);
      r_issue_id     <= '0;
      r_fpu_valid_in <= 1'b0;
      r_fpu_a        <= '0;
      r_fpu_b        <= '0;
      r_tag_v        <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_tag_err      <= 1'b0;
      for (int s = 0; s <= PIPE_LAT; s++) r_tag_id[s] <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_fpu_valid_in <= w_hit;
      if (w_hit) begin
        r_fpu_a    <= w_a[w_sel];
        r_fpu_b    <= {w_b[w_sel][31] ^ io_bus.req_op[w_sel], w_b[w_sel][30:0]};
        r_ptr      <= w_sel;
        r_issue_id <= w_sel;
      end
      r_tag_v     <= {r_tag_v[PIPE_LAT-1:0], r_fpu_valid_in};
      r_tag_id[0] <= r_issue_id;
      for (int s = 1; s <= PIPE_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
      r_rsp_data  <= io_bus.fpu_ans;
      r_rsp_valid <= w_rsp_next;
      if (w_mis) r_tag_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        r_cnt[i] <= r_cnt[i] + CW'(w_grant[i]) - CW'(w_rsp_next[i] && r_cnt[i] != '0);
    end
  end

  assign io_bus.req_ready    = w_grant;
  assign io_bus.fpu_a        = r_fpu_a;
  assign io_bus.fpu_b        = r_fpu_b;
  assign io_bus.fpu_valid_in = r_fpu_valid_in;
  assign io_bus.rsp_valid    = r_rsp_valid;
  assign io_bus.rsp_data     = r_rsp_data;
  assign io_bus.tag_err      = r_tag_err;
  assign io_bus.busy         = r_fpu_valid_in | (|r_tag_v) | (|r_rsp_valid);
endmodule

// File: tb/tb_fpu_sub_arbiter.sv
// tb_fpu_sub_arbiter: randomized and directed check of fpu_sub_arbiter against a queue-based reference
module tb_fpu_sub_arbiter;
  localparam int N  = 4;
  localparam int PL = 3;
  localparam int MI = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inj = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_sub_arbiter_if #(.NUM_REQ(N)) bus ();
  fpu_sub_arbiter #(.NUM_REQ(N), .PIPE_LAT(PL), .MAX_INFLIGHT(MI)) dut (
    .clk(clk), .reset(reset), .io_bus(bus)
  );

  function automatic real s2r(logic [31:0] x);
    logic [10:0] e;
    e = 11'(x[30:23]) + 11'd896;
    return (x[30:0] == 31'b0) ? 0.0 : $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return (r == 0.0) ? 32'h0 : {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Shared FPU stand-in: samples the issue port and presents a-b PIPE_LAT edges later.
  logic        pv [PL+1];
  logic [31:0] pd [PL+1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PL; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= bus.fpu_valid_in;
      pd[0] <= r2s(s2r(bus.fpu_a) - s2r(bus.fpu_b));
      for (int i = 1; i <= PL; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign bus.fpu_valid_out = pv[PL] | inj;
  assign bus.fpu_ans       = pd[PL];

  typedef struct {
    int          id;
    logic [31:0] d;
    int          due;
  } ent_t;

  ent_t        sb[$];
  int          gq[$];
  int          rcnt[N];
  int          mptr = N - 1;
  logic        exp_fv = 1'b0;
  logic        exp_terr = 1'b0;
  logic        pend_terr = 1'b0;
  logic [31:0] exp_fa = '0;
  logic [31:0] exp_fb = '0;

  always @(negedge clk) begin : mon
    logic [N-1:0] er;
    logic [N-1:0] rdy;
    logic [31:0]  ed;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         bz;
    int           cnt[N];
    int           q;
    ent_t         keep[$];
    #2;
    for (int i = 0; i < N; i++) if (bus.rsp_valid[i]) rcnt[i]++;
    if (reset) begin
      sb.delete();
      mptr = N - 1;
      exp_fv = 1'b0;
      exp_terr = 1'b0;
      pend_terr = 1'b0;
      chk("rst_ctl", {21'b0, bus.req_ready, bus.rsp_valid, bus.fpu_valid_in, bus.busy, bus.tag_err}, 32'h0);
      chk("rst_data", bus.fpu_a | bus.fpu_b | bus.rsp_data, 32'h0);
    end else begin
      er = '0;
      ed = '0;
      bz = 1'b0;
      keep = {};
      foreach (sb[k]) begin
        if (sb[k].due == cyc) begin
          er[sb[k].id] = 1'b1;
          ed = sb[k].d;
        end else keep.push_back(sb[k]);
        if (cyc >= sb[k].due - (PL + 2) && cyc <= sb[k].due) bz = 1'b1;
      end
      sb = keep;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(er));
      if (er != '0) chk("rsp_data", bus.rsp_data, ed);
      chk("busy", 32'(bus.busy), 32'(bz));
      chk("fpu_valid_in", 32'(bus.fpu_valid_in), 32'(exp_fv));
      if (exp_fv) begin
        chk("fpu_a", bus.fpu_a, exp_fa);
        chk("fpu_b", bus.fpu_b, exp_fb);
      end
      if (pend_terr) exp_terr = 1'b1;
      pend_terr = inj;
      chk("tag_err", 32'(bus.tag_err), 32'(exp_terr));
      for (int i = 0; i < N; i++) cnt[i] = 0;
      foreach (sb[k]) cnt[sb[k].id]++;
      rdy = '0;
      if (!bus.hold)
        for (int j = 1; j <= N; j++) begin
          q = (mptr + j) % N;
          if (rdy == '0 && bus.req_valid[q] && cnt[q] < MI) rdy[q] = 1'b1;
        end
      chk("req_ready", 32'(bus.req_ready), 32'(rdy));
      exp_fv = 1'b0;
      for (int i = 0; i < N; i++)
        if (rdy[i]) begin
          a = bus.req_a[32*i +: 32];
          b = bus.req_b[32*i +: 32];
          sb.push_back('{id: i, d: r2s(bus.req_op[i] ? s2r(a) + s2r(b) : s2r(a) - s2r(b)), due: cyc + PL + 3});
          gq.push_back(i);
          mptr = i;
          exp_fv = 1'b1;
          exp_fa = a;
          exp_fb = {b[31] ^ bus.req_op[i], b[30:0]};
        end
    end
  end

  task automatic set_req(int i, logic v, logic op, logic [31:0] a, logic [31:0] b);
    bus.req_valid[i] = v;
    bus.req_op[i] = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic idle(int n);
    bus.req_valid = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(int i, logic op, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    set_req(i, 1'b1, op, a, b);
    @(negedge clk);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(int i, logic [31:0] d);
    int n;
    for (n = 0; n < 12; n++) begin
      @(negedge clk);
      #3;
      if (bus.rsp_valid != '0) break;
    end
    chk("rsp_latency", n, PL + 1);
    chk("rsp_id", 32'(bus.rsp_valid), 32'(1 << i));
    chk("rsp_value", bus.rsp_data, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    #2 chk("rst_busy", 32'(bus.busy), 32'h0);
    #1 reset = 1'b0;
  endtask

  task automatic clr_rcnt();
    for (int i = 0; i < N; i++) rcnt[i] = 0;
  endtask

  initial begin
    int tot;
    bus.hold = 1'b0;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    send(0, 1'b0, 32'h41200000, 32'h40400000);
    #3 chk("sub_fpu_b", bus.fpu_b, 32'h40400000);
    wait_rsp(0, 32'h40E00000);
    send(2, 1'b1, 32'h40700000, 32'h3FA00000);
    #3 chk("add_fpu_b", bus.fpu_b, 32'hBFA00000);
    wait_rsp(2, 32'h40A00000);
    idle(4);

    do_reset();
    gq.delete();
    clr_rcnt();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'($urandom), rnd_f(), rnd_f());
    repeat (8) @(negedge clk);
    idle(10);
    #3 chk("rr_count", gq.size(), 8);
    for (int j = 0; j < gq.size() && j < 8; j++) chk("rr_order", gq[j], j % N);
    for (int i = 0; i < N; i++) chk("rr_rsps", rcnt[i], 2);

    gq.delete();
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, rnd_f(), rnd_f());
    repeat (12) @(negedge clk);
    bus.req_valid = '0;
    #3 chk("inflight_grants", gq.size(), 4);
    idle(10);

    gq.delete();
    clr_rcnt();
    @(negedge clk);
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'($urandom), rnd_f(), rnd_f());
    repeat (3) @(negedge clk);
    bus.hold = 1'b1;
    set_req(3, 1'b1, 1'b0, rnd_f(), rnd_f());
    #3 chk("hold_pre_grants", gq.size(), 3);
    gq.delete();
    repeat (10) @(negedge clk);
    #3 chk("hold_grants", gq.size(), 0);
    tot = 0;
    for (int i = 0; i < N; i++) tot += rcnt[i];
    chk("hold_rsps", tot, 3);
    chk("hold_busy", 32'(bus.busy), 32'h0);
    bus.hold = 1'b0;
    idle(2);

    clr_rcnt();
    send(3, 1'b0, rnd_f(), rnd_f());
    do_reset();
    idle(10);
    #3 chk("rst_mid_no_rsp", rcnt[3], 0);

    idle(3);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #3 chk("terr_set", 32'(bus.tag_err), 32'h1);
    chk("terr_rsp", 32'(bus.rsp_valid), 32'h0);
    idle(5);
    #3 chk("terr_sticky", 32'(bus.tag_err), 32'h1);
    do_reset();
    #1 chk("terr_clear", 32'(bus.tag_err), 32'h0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(2, 0) != 0, 1'($urandom), rnd_f(), rnd_f());
      bus.hold = $urandom_range(15, 0) == 0;
    end
    bus.hold = 1'b0;
    idle(12);
    #3 chk("final_busy", 32'(bus.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_sub_arbiter.md
Name: fpu_sub_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 3-stage pipelined IEEE-754 single-precision subtractor among NUM_REQ requesters. Each requester issues add or subtract requests over a valid/ready handshake. The arbiter registers one operation per cycle into the FPU and carries a requester tag alongside the pipeline. It returns each result to its originator with a per-requester in-flight limit. The block sits between the scalar FP issue ports and the shared FP add/sub datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
PIPE_LAT, 3, FPU latency in clock edges from sampled fpu_valid_in to fpu_valid_out
MAX_INFLIGHT, 2, maximum outstanding operations per requester (1..7)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
hold  in  1  1 = grant nothing new; in-flight ops still complete
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_op  in  NUM_REQ  per-requester op: 0 = a-b, 1 = a+b
req_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i]
req_b  in  NUM_REQ*32  operand B, same packing
rsp_valid  out  NUM_REQ  one-cycle result strobe to the owning requester
rsp_data  out  32  result, shared by all requesters; qualified by rsp_valid
fpu_a  out  32  registered operand A to the FPU
fpu_b  out  32  registered operand B to the FPU; sign already adjusted for op
fpu_valid_in  out  1  registered FPU issue strobe
fpu_ans  in  32  FPU result
fpu_valid_out  in  1  FPU result valid
busy  out  1  any operation in flight
tag_err  out  1  sticky tag/valid misalignment flag

Behaviour:
- Reset: all outputs 0; RR pointer = NUM_REQ-1, so requester 0 has first priority. In-flight counters 0, tag pipe cleared, tag_err 0. The FPU shares the same reset, so a reset mid-operation discards all in-flight ops and no rsp_valid follows.
- Eligibility: elig[i] = req_valid[i] & (inflight[i] < MAX_INFLIGHT) & !hold.
- Arbitration (combinational): scan from (ptr+1) mod NUM_REQ upward, wrapping. req_ready = one-hot of the first eligible requester, else 0. req_ready never depends on rsp_valid.
- Handshake: accepted at edge k when req_valid[i] & req_ready[i]. At edge k:
  - fpu_a <= req_a[i]
  - fpu_b <= {req_b[i][31]^req_op[i], req_b[i][30:0]} (add is implemented as a-(-b))
  - fpu_valid_in <= 1
  - ptr <= i
  - tag_pipe[0] <= {1, i}
- No grant at edge k: fpu_valid_in <= 0, fpu_a/fpu_b hold their previous value, ptr unchanged, tag_pipe[0] <= {0, x}.
- Tag pipe: PIPE_LAT+1 entries of {valid, id}, shifting every edge. Entry PIPE_LAT is aligned with fpu_valid_out.
- Result: at each edge, rsp_data <= fpu_ans, and rsp_valid <= onehot(tag id) if fpu_valid_out else 0.
  - Total latency: handshake edge k -> rsp_valid high in the cycle after edge k+PIPE_LAT+2 (k+5 at default). Exactly one cycle wide.
  - No backpressure on the response side: requesters must accept.
- Tag check: if fpu_valid_out != tag valid bit at the aligned entry, tag_err <= 1 (sticky until reset) and rsp_valid <= 0 that edge.
- In-flight counter i (width clog2(MAX_INFLIGHT+1)):
  - +1 on grant to i
  - -1 when rsp_valid[i] is set
  - both in the same edge: unchanged
  - never wraps; saturation is a design error
- Throughput: one grant per cycle, sustained. Back-to-back grants to the same requester are allowed up to MAX_INFLIGHT.
- hold: when 1, req_ready = 0 and fpu_valid_in falls at the next edge. The pipeline drains normally. Deasserting hold resumes arbitration from the current ptr.
- busy = fpu_valid_in | any tag_pipe valid | any rsp_valid.

Test Plan:
- Single op: req 0 sends a=0x41200000 (10.0), b=0x40400000 (3.0), op=0 at edge k -> fpu_b=0x40400000, rsp_valid[0] in the cycle after edge k+5, rsp_data=0x40E00000 (7.0); no other rsp_valid asserted.
- Add via sign flip: req 2 sends a=0x40700000 (3.75), b=0x3FA00000 (1.25), op=1 -> fpu_b=0xBFA00000, rsp_valid[2], rsp_data=0x40A00000 (5.0).
- Round-robin fairness: all 4 requesters hold valid for 8 cycles, MAX_INFLIGHT=2 -> grant order 0,1,2,3,0,1,2,3. Each requester receives exactly 2 responses, in order, with correct ids.
- In-flight limit: only req 1 valid continuously -> grants at 2 consecutive edges, then ready=0 until its first rsp_valid edge, then a single re-grant in that cycle; counter never exceeds 2.
- Hold and reset mid-flight: assert hold with 3 ops in flight -> no new ready, 3 responses still return, busy falls afterwards. Separately, pulse reset 2 cycles after a grant -> all outputs 0, no rsp_valid ever appears for that op.
- Tag error: force fpu_valid_out=1 with an empty tag pipe -> tag_err=1, rsp_valid stays 0, tag_err persists until reset.
